// File: rtl/fm_carrier_sweep_ctrl_pkg.sv
// Shared definitions for the FM carrier-frequency sweep controller.
// State encodings and default widths.
package fm_carrier_sweep_ctrl_pkg;

    localparam int FW_DEF = 48;
    localparam int CW_DEF = 16;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

endpackage

// File: rtl/fm_carrier_sweep_ctrl_dwell_timer.sv
// Loadable down-counter holding each tuning word for its dwell time.
// Saturates at zero and flags it.
module fm_carrier_sweep_ctrl_dwell_timer #(
    parameter int DW = 32
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Next count: load wins over decrement, never below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fm_carrier_sweep_ctrl.sv
// Linear stepped sweep of the FM carrier tuning word.
// Drives the carrier register Din/EN pair via FreqOut/FreqLoad.
module fm_carrier_sweep_ctrl
    import fm_carrier_sweep_ctrl_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int CW = CW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Abort,
    input  logic [FW-1:0] StartFreq,
    input  logic [FW-1:0] StepFreq,
    input  logic [CW-1:0] StepCount,
    input  logic [DW-1:0] Dwell,
    input  logic          Continuous,
    output logic [FW-1:0] FreqOut,
    output logic          FreqLoad,
    output logic          Busy,
    output logic          Done
);

    state_e        state_q, state_d;
    logic [FW-1:0] freq_q, freq_d;
    logic          load_q, load_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [FW-1:0] start_l_q, start_l_d;
    logic [FW-1:0] step_l_q, step_l_d;
    logic [CW-1:0] cnt_l_q, cnt_l_d;
    logic [DW-1:0] dwell_l_q, dwell_l_d;
    logic          cont_l_q, cont_l_d;
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_zero;
    logic [DW-1:0] tmr_val;

    // A dwell of zero behaves like a dwell of one.
    assign tmr_val = (dwell_l_q == '0) ? '0 : dwell_l_q - DW'(1);

    fm_carrier_sweep_ctrl_dwell_timer #(
        .DW(DW)
    ) u_dwell (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .dec     (tmr_dec),
        .zero    (tmr_zero)
    );

    // Sweep sequencing; strobes are computed one cycle early so they register cleanly.
    always_comb begin
        state_d   = state_q;
        freq_d    = freq_q;
        load_d    = 1'b0;
        done_d    = 1'b0;
        idx_d     = idx_q;
        start_l_d = start_l_q;
        step_l_d  = step_l_q;
        cnt_l_d   = cnt_l_q;
        dwell_l_d = dwell_l_q;
        cont_l_d  = cont_l_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        if (Abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        start_l_d = StartFreq;
                        step_l_d  = StepFreq;
                        cnt_l_d   = StepCount;
                        dwell_l_d = Dwell;
                        cont_l_d  = Continuous;
                        freq_d    = StartFreq;
                        idx_d     = '0;
                        load_d    = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tmr_load = 1'b1;
                    state_d  = ST_DWELL;
                end
                ST_DWELL: begin
                    if (!tmr_zero) begin
                        tmr_dec = 1'b1;
                    end else begin
                        done_d  = (idx_q == cnt_l_q) && !cont_l_q;
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (idx_q != cnt_l_q) begin
                        freq_d  = freq_q + step_l_q;
                        idx_d   = idx_q + CW'(1);
                        load_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else if (cont_l_q) begin
                        freq_d  = start_l_q;
                        idx_d   = '0;
                        load_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            freq_q    <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            start_l_q <= '0;
            step_l_q  <= '0;
            cnt_l_q   <= '0;
            dwell_l_q <= '0;
            cont_l_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            freq_q    <= freq_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            start_l_q <= start_l_d;
            step_l_q  <= step_l_d;
            cnt_l_q   <= cnt_l_d;
            dwell_l_q <= dwell_l_d;
            cont_l_q  <= cont_l_d;
        end
    end

    assign FreqOut  = freq_q;
    assign FreqLoad = load_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_fm_carrier_sweep_ctrl.sv
// Bench for the FM carrier sweep controller.
// Expected timing comes from word-index arithmetic.
module tb_fm_carrier_sweep_ctrl;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Abort;
    logic [47:0] StartFreq;
    logic [47:0] StepFreq;
    logic [15:0] StepCount;
    logic [31:0] Dwell;
    logic        Continuous;
    logic [47:0] FreqOut;
    logic        FreqLoad;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;
    logic [47:0] last_word = '0;

    fm_carrier_sweep_ctrl dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Abort     (Abort),
        .StartFreq (StartFreq),
        .StepFreq  (StepFreq),
        .StepCount (StepCount),
        .Dwell     (Dwell),
        .Continuous(Continuous),
        .FreqOut   (FreqOut),
        .FreqLoad  (FreqLoad),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] word(input logic [47:0] s,
                                         input logic [47:0] st,
                                         input int idx);
        logic [47:0] i48;
        i48 = 48'(idx);
        return s + st * i48;
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    task automatic scramble_cfg();
        StartFreq  = rnd48();
        StepFreq   = rnd48();
        StepCount  = 16'($urandom);
        Dwell      = $urandom;
        Continuous = 1'($urandom);
    endtask

    // Non-continuous sweep; a stray Start with new config is fired mid-sweep.
    task automatic run_sweep(input logic [47:0] s, input logic [47:0] st,
                             input int n, input int d);
        int dp, per, t, w;
        logic [47:0] ew;
        dp  = (d < 1) ? 1 : d;
        per = dp + 2;
        t   = (n + 1) * per;
        StartFreq  = s;
        StepFreq   = st;
        StepCount  = 16'(n);
        Dwell      = 32'(d);
        Continuous = 1'b0;
        Start      = 1'b1;
        step();
        Start = 1'b0;
        for (int k = 1; k <= t + 2; k++) begin
            w  = (((k < t) ? k : t) - 1) / per;
            ew = word(s, st, w);
            chk("sweep_load", 64'(FreqLoad),
                64'((k <= t) && ((k - 1) % per == 0)));
            chk("sweep_done", 64'(Done), 64'(k == t));
            chk("sweep_busy", 64'(Busy), 64'(k <= t));
            chk("sweep_freq", 64'(FreqOut), 64'(ew));
            if (k == 2) begin
                scramble_cfg();
                Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            step();
        end
        Start     = 1'b0;
        last_word = word(s, st, n);
    endtask

    // Continuous sweep, aborted during a dwell cycle at observed cycle kab.
    task automatic cont_abort(input logic [47:0] s, input logic [47:0] st,
                              input int n, input int d, input int kab);
        int dp, per, w;
        logic [47:0] ew;
        dp  = (d < 1) ? 1 : d;
        per = dp + 2;
        StartFreq  = s;
        StepFreq   = st;
        StepCount  = 16'(n);
        Dwell      = 32'(d);
        Continuous = 1'b1;
        Start      = 1'b1;
        step();
        Start = 1'b0;
        ew    = s;
        for (int k = 1; k <= kab; k++) begin
            w  = ((k - 1) / per) % (n + 1);
            ew = word(s, st, w);
            chk("cont_load", 64'(FreqLoad), 64'((k - 1) % per == 0));
            chk("cont_done", 64'(Done), 64'(0));
            chk("cont_freq", 64'(FreqOut), 64'(ew));
            if (k == kab) Abort = 1'b1;
            step();
        end
        Abort = 1'b0;
        for (int k = 0; k < per + 2; k++) begin
            chk("abort_busy", 64'(Busy), 64'(0));
            chk("abort_load", 64'(FreqLoad), 64'(0));
            chk("abort_done", 64'(Done), 64'(0));
            chk("abort_freq", 64'(FreqOut), 64'(ew));
            step();
        end
        last_word = ew;
    endtask

    initial begin
        Reset      = 1'b0;
        Start      = 1'b0;
        Abort      = 1'b0;
        StartFreq  = '0;
        StepFreq   = '0;
        StepCount  = '0;
        Dwell      = '0;
        Continuous = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_freq", 64'(FreqOut), 64'(0));
            chk("rst_flags", 64'({FreqLoad, Busy, Done}), 64'(0));
        end
        Reset = 1'b1;
        step();

        run_sweep(48'h1000, 48'h10, 3, 4);
        run_sweep(48'h8, 48'hFFFF_FFFF_FFF0, 1, 0);
        cont_abort(48'h2000, 48'h100, 1, 3, 13);

        Start = 1'b1;
        Abort = 1'b1;
        step();
        Start = 1'b0;
        Abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("coll_busy", 64'(Busy), 64'(0));
            chk("coll_load", 64'(FreqLoad), 64'(0));
            chk("coll_freq", 64'(FreqOut), 64'(last_word));
            step();
        end

        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("idle_abort", 64'({FreqLoad, Busy, Done}), 64'(0));

        run_sweep(48'hABCD_0000_1234, 48'h1, 0, 1);

        for (int r = 0; r < 8; r++) begin
            run_sweep(rnd48(), rnd48(), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 5)));
        end
        cont_abort(rnd48(), rnd48(), 2, 2, 7);

        StartFreq  = 48'h5555;
        StepFreq   = 48'h1;
        StepCount  = 16'd3;
        Dwell      = 32'd5;
        Continuous = 1'b0;
        Start      = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_freq", 64'(FreqOut), 64'(0));
            chk("mid_rst_flags", 64'({FreqLoad, Busy, Done}), 64'(0));
        end
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst", 64'({FreqLoad, Busy, Done}), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
